// File: rtl/add_sub_pkg.sv
// Opmode encoding and decode helpers for the pipelined add/sub accumulator.
package add_sub_pkg;

   typedef enum logic [1:0] {
      OP_ADD     = 2'b00,
      OP_SUB     = 2'b01,
      OP_ACC_ADD = 2'b10,
      OP_ACC_SUB = 2'b11
   } opmode_t;

   function automatic logic is_sub_op(opmode_t m);
      return (m == OP_SUB) || (m == OP_ACC_SUB);
   endfunction

   function automatic logic is_acc_op(opmode_t m);
      return (m == OP_ACC_ADD) || (m == OP_ACC_SUB);
   endfunction

endpackage

// File: rtl/add_sub_acc_pipe_if.sv
// Operation request / result bundle between a source and add_sub_acc_pipe.
interface add_sub_acc_pipe_if #(parameter int WIDTH = 48);
   import add_sub_pkg::*;

   logic             in_valid;
   logic             in_ready;
   opmode_t          opmode;
   logic [WIDTH-1:0] in1;
   logic [WIDTH-1:0] in2;
   logic             cin;
   logic             acc_clr;
   logic             out_valid;
   logic [WIDTH-1:0] out;
   logic             cout;
   logic             ovf;

   modport master (
      output in_valid, opmode, in1, in2, cin, acc_clr,
      input  in_ready, out_valid, out, cout, ovf
   );

   modport slave (
      input  in_valid, opmode, in1, in2, cin, acc_clr,
      output in_ready, out_valid, out, cout, ovf
   );

endinterface

// File: rtl/add_sub_seg.sv
// One registered carry-chain segment: sum slice, carry out, and (top segment only) signed overflow.
module add_sub_seg #(
   parameter int SEG_W = 24,
   parameter bit LAST  = 1'b0
) (
   input  logic             clk,
   input  logic [SEG_W-1:0] a,
   input  logic [SEG_W-1:0] b,
   input  logic             cin,
   output logic [SEG_W-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   logic [SEG_W:0] ext;
   logic           ovf_c;

   assign ext = {1'b0, a} + {1'b0, b} + {{SEG_W{1'b0}}, cin};

   // b is already inverted for subtraction, so one rule covers both directions
   always_comb begin
      ovf_c = 1'b0;
      if (LAST)
         ovf_c = (a[SEG_W-1] == b[SEG_W-1]) && (ext[SEG_W-1] != a[SEG_W-1]);
   end

   always_ff @(posedge clk) begin
      sum  <= ext[SEG_W-1:0];
      cout <= ext[SEG_W];
      ovf  <= ovf_c;
   end

endmodule

// File: rtl/add_sub_acc_pipe.sv
// Carry-segmented pipelined add/sub with accumulator, valid/ready input and overflow flag.
module add_sub_acc_pipe
   import add_sub_pkg::*;
#(
   parameter int WIDTH = 48,
   parameter int SEG   = 2
) (
   input logic               clk,
   input logic               rst,
   add_sub_acc_pipe_if.slave bus
);

   localparam int SEG_W = WIDTH / SEG;   // WIDTH must be a multiple of SEG

   logic                     is_sub, is_acc, accept, busy, wb, c_in;
   logic signed [WIDTH-1:0]  acc, acc_fwd, a_in, b_in, res_p;
   logic [SEG-1:0]           vld_p, sub_p, accf_p, carry_s, ovf_s;
   logic [SEG_W-1:0]         sum_s  [SEG];
   logic [SEG_W-1:0]         res_sl [SEG];
   logic                     result_vld, carry, overflow;
   logic signed [WIDTH-1:0]  result;

   assign is_sub = is_sub_op(bus.opmode);
   assign is_acc = is_acc_op(bus.opmode);
   assign accept = bus.in_valid & bus.in_ready;

   // An ACC op in any stage but the last blocks new ops until its write-back edge
   always_comb begin
      busy = 1'b0;
      for (int k = 0; k < SEG - 1; k++)
         busy = busy | (vld_p[k] & accf_p[k]);
   end

   assign bus.in_ready = ~rst & ~busy;
   assign wb           = vld_p[SEG-1] & accf_p[SEG-1];

   // The op accepted on a write-back edge must see the value being written
   assign acc_fwd = wb ? res_p : acc;
   assign a_in    = is_acc ? acc_fwd : bus.in1;
   assign b_in    = is_sub ? ~bus.in2 : bus.in2;
   assign c_in    = bus.cin ^ is_sub;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p  <= '0;
         sub_p  <= '0;
         accf_p <= '0;
      end else begin
         vld_p[0]  <= accept;
         sub_p[0]  <= is_sub;
         accf_p[0] <= accept & is_acc;
         for (int k = 1; k < SEG; k++) begin
            vld_p[k]  <= vld_p[k-1];
            sub_p[k]  <= sub_p[k-1];
            accf_p[k] <= accf_p[k-1];
         end
      end
   end

   for (genvar k = 0; k < SEG; k++) begin : g_seg
      logic [SEG_W-1:0] a_k, b_k;
      logic             c_k;

      if (k == 0) begin : g_first
         assign a_k = a_in[SEG_W-1:0];
         assign b_k = b_in[SEG_W-1:0];
         assign c_k = c_in;
      end else begin : g_skew
         logic [SEG_W-1:0] a_skw [k];
         logic [SEG_W-1:0] b_skw [k];
         always_ff @(posedge clk) begin
            a_skw[0] <= a_in[k*SEG_W +: SEG_W];
            b_skw[0] <= b_in[k*SEG_W +: SEG_W];
            for (int j = 1; j < k; j++) begin
               a_skw[j] <= a_skw[j-1];
               b_skw[j] <= b_skw[j-1];
            end
         end
         assign a_k = a_skw[k-1];
         assign b_k = b_skw[k-1];
         assign c_k = carry_s[k-1];
      end

      add_sub_seg #(.SEG_W(SEG_W), .LAST(k == SEG - 1)) u_seg (
         .clk  (clk),
         .a    (a_k),
         .b    (b_k),
         .cin  (c_k),
         .sum  (sum_s[k]),
         .cout (carry_s[k]),
         .ovf  (ovf_s[k])
      );

      if (k == SEG - 1) begin : g_top
         assign res_sl[k] = sum_s[k];
      end else begin : g_deskew
         logic [SEG_W-1:0] dsk [SEG-1-k];
         always_ff @(posedge clk) begin
            dsk[0] <= sum_s[k];
            for (int j = 1; j < SEG - 1 - k; j++)
               dsk[j] <= dsk[j-1];
         end
         assign res_sl[k] = dsk[SEG-2-k];
      end
   end

   always_comb begin
      res_p = '0;
      for (int k = 0; k < SEG; k++)
         res_p[k*SEG_W +: SEG_W] = res_sl[k];
   end

   // Output stage: result, flags and accumulator all update on the same edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result_vld <= 1'b0;
         result     <= '0;
         carry      <= 1'b0;
         overflow   <= 1'b0;
         acc        <= '0;
      end else begin
         result_vld <= vld_p[SEG-1];
         if (vld_p[SEG-1]) begin
            result   <= res_p;
            carry    <= carry_s[SEG-1] ^ sub_p[SEG-1];
            overflow <= |ovf_s;
         end
         if (bus.acc_clr)
            acc <= '0;
         else if (wb)
            acc <= res_p;
      end
   end

   assign bus.out_valid = result_vld;
   assign bus.out       = result;
   assign bus.cout      = carry;
   assign bus.ovf       = overflow;

endmodule
